// File: rtl/line_raster_engine_if.sv
// Command and pixel-stream bundle for line_raster_engine.
// master drives line commands and consumes pixels; slave is the engine.
interface line_raster_engine_if #(
    parameter int COORD_W = 12,
    parameter int COLOR_W = 8
);
    logic                      start;
    logic signed [COORD_W-1:0] x0;
    logic signed [COORD_W-1:0] y0;
    logic signed [COORD_W-1:0] x1;
    logic signed [COORD_W-1:0] y1;
    logic [COLOR_W-1:0]        color;
    logic                      abort;
    logic                      busy;
    logic                      done;
    logic                      pix_valid;
    logic                      pix_ready;
    logic [COORD_W-2:0]        pix_x;
    logic [COORD_W-2:0]        pix_y;
    logic [COLOR_W-1:0]        pix_color;
    logic [COORD_W:0]          pix_count;

    modport master (
        output start, x0, y0, x1, y1, color, abort, pix_ready,
        input  busy, done, pix_valid, pix_x, pix_y, pix_color, pix_count
    );

    modport slave (
        input  start, x0, y0, x1, y1, color, abort, pix_ready,
        output busy, done, pix_valid, pix_x, pix_y, pix_color, pix_count
    );
endinterface

// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: one signed-endpoint command in, a clipped
// valid/ready stream of pixel coordinates out.
module line_raster_engine #(
    parameter int COORD_W  = 12,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int COLOR_W  = 8,
    parameter int CLIP_EN  = 1
) (
    input logic                 clk,
    input logic                 rst,
    line_raster_engine_if.slave bus
);
    localparam int CW    = COORD_W + 2;
    localparam int CNT_W = COORD_W + 1;
    localparam logic signed [CW-1:0] SCR_W = CW'(SCREEN_W);
    localparam logic signed [CW-1:0] SCR_H = CW'(SCREEN_H);

    typedef enum logic [2:0] {StIdle, StLoad, StSetup, StInit, StStep, StDone} state_e;

    state_e state_q, state_d;

    // a = current point (start point before INIT), b = end point
    logic signed [CW-1:0] ax_q, ax_d, ay_q, ay_d;
    logic signed [CW-1:0] bx_q, bx_d, by_q, by_d;
    logic signed [CW-1:0] dx_q, dx_d, dy_q, dy_d;
    logic signed [CW-1:0] err_q, err_d;
    logic                 steep_q, steep_d;
    logic                 ystep_neg_q, ystep_neg_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic signed [CW-1:0] adx, ady, err_inc, px, py;
    logic                 visible, handshake, advance;

    always_comb begin
        adx = (bx_q >= ax_q) ? (bx_q - ax_q) : (ax_q - bx_q);
        ady = (by_q >= ay_q) ? (by_q - ay_q) : (ay_q - by_q);
        px  = steep_q ? ay_q : ax_q;
        py  = steep_q ? ax_q : ay_q;
        visible = (CLIP_EN == 0) ||
                  (!px[CW-1] && (px < SCR_W) && !py[CW-1] && (py < SCR_H));
        handshake = (state_q == StStep) && visible && bus.pix_ready;
        // invisible candidates retire without waiting for the consumer
        advance   = (state_q == StStep) && (!visible || bus.pix_ready);
        err_inc   = err_q + dy_q;
    end

    always_comb begin
        state_d     = state_q;
        ax_d        = ax_q;
        ay_d        = ay_q;
        bx_d        = bx_q;
        by_d        = by_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        steep_d     = steep_q;
        ystep_neg_d = ystep_neg_q;
        color_d     = color_q;
        count_d     = count_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    ax_d    = {{2{bus.x0[COORD_W-1]}}, bus.x0};
                    ay_d    = {{2{bus.y0[COORD_W-1]}}, bus.y0};
                    bx_d    = {{2{bus.x1[COORD_W-1]}}, bus.x1};
                    by_d    = {{2{bus.y1[COORD_W-1]}}, bus.y1};
                    color_d = bus.color;
                    count_d = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                steep_d = ady > adx;
                if (ady > adx) begin
                    ax_d = ay_q;
                    ay_d = ax_q;
                    bx_d = by_q;
                    by_d = bx_q;
                end
                state_d = StSetup;
            end
            StSetup: begin
                if (ax_q > bx_q) begin
                    ax_d = bx_q;
                    ay_d = by_q;
                    bx_d = ax_q;
                    by_d = ay_q;
                end
                state_d = StInit;
            end
            StInit: begin
                dx_d        = bx_q - ax_q;
                dy_d        = ady;
                err_d       = -((bx_q - ax_q) >>> 1);
                ystep_neg_d = !(ay_q < by_q);
                state_d     = StStep;
            end
            StStep: begin
                if (advance) begin
                    ax_d = ax_q + CW'(1);
                    if (!err_inc[CW-1] && (err_inc != '0)) begin
                        ay_d  = ystep_neg_q ? (ay_q - CW'(1)) : (ay_q + CW'(1));
                        err_d = err_inc - dx_q;
                    end else begin
                        err_d = err_inc;
                    end
                    if (ax_q == bx_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (handshake) begin
            count_d = count_q + CNT_W'(1);
        end
        // abort wins over any transition; a same-cycle handshake still counts
        if (bus.abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ax_q        <= '0;
            ay_q        <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            steep_q     <= 1'b0;
            ystep_neg_q <= 1'b0;
            color_q     <= '0;
            count_q     <= '0;
        end else begin
            ax_q        <= ax_d;
            ay_q        <= ay_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            steep_q     <= steep_d;
            ystep_neg_q <= ystep_neg_d;
            color_q     <= color_d;
            count_q     <= count_d;
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.pix_valid = (state_q == StStep) && visible;
    assign bus.pix_x     = px[COORD_W-2:0];
    assign bus.pix_y     = py[COORD_W-2:0];
    assign bus.pix_color = color_q;
    assign bus.pix_count = count_q;
endmodule

// File: doc/line_raster_engine.md
Name: line_raster_engine

Overview:
- Parametrised Bresenham line rasteriser for the hexagon renderer. It accepts one signed-endpoint line command per start/busy handshake and emits inclusive pixel coordinates on a valid/ready stream toward the frame-buffer writer.
- Beyond a fixed 32-bit drawer, it adds: configurable coordinate width, per-line colour, screen-bounds clipping, streaming backpressure, an abort input, and a pixel count.

Parameters:
- COORD_W, 12: signed endpoint width in bits; internal error/delta registers are COORD_W+2 bits.
- SCREEN_W, 640: horizontal visible extent; pixels with x in [0, SCREEN_W-1] are visible.
- SCREEN_H, 480: vertical visible extent; pixels with y in [0, SCREEN_H-1] are visible.
- COLOR_W, 8: colour width in bits.
- CLIP_EN, 1: 1 suppresses off-screen pixels; 0 emits every pixel, with coordinates truncated to their low bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  command strobe; sampled only while busy=0
- x0, y0, x1, y1  in  COORD_W  signed endpoints (two's complement)
- color  in  COLOR_W  line colour, captured with the endpoints
- abort  in  1  cancel the current line
- busy  out  1  high from the cycle after start is accepted until the engine returns to IDLE
- done  out  1  one-cycle pulse after the last pixel of a line is retired
- pix_valid  out  1  pixel available
- pix_ready  in  1  consumer accepts the pixel
- pix_x  out  COORD_W-1  unsigned pixel x
- pix_y  out  COORD_W-1  unsigned pixel y
- pix_color  out  COLOR_W  captured colour
- pix_count  out  COORD_W+1  number of pixels accepted for the current or last line

Behaviour:
- Reset values: every output is 0 and the state is IDLE. Reset may be asserted mid-line; it abandons the line immediately, and no done pulse is produced.
- States: IDLE -> LOAD -> SETUP -> INIT -> STEP -> DONE -> IDLE.
- IDLE: when start=1, capture endpoints and colour, clear pix_count, go to LOAD. busy=0 only in IDLE. A start seen in any other state is ignored.
- LOAD: steep = |y1-y0| > |x1-x0|. If steep, swap x<->y on both endpoints. Go to SETUP.
- SETUP: if x0 > x1, swap the two endpoints. Go to INIT.
- INIT:
  - dx = x1-x0 (>= 0); dy = |y1-y0|.
  - err = -(dx >>> 1), arithmetic shift.
  - ystep = +1 if y0 < y1, else -1.
  - x = x0, y = y0. Go to STEP.
- STEP, one candidate pixel per cycle:
  - The plotted pixel is (y,x) if steep, otherwise (x,y).
  - A pixel is visible when CLIP_EN=0, or when it lies inside the screen bounds.
  - If visible: assert pix_valid. pix_x, pix_y and pix_color stay stable until pix_valid && pix_ready.
  - Advance only on handshake (visible pixel) or immediately (invisible pixel).
  - Advance rule: err += dy; if the new err > 0, then y += ystep and err -= dx; x += 1.
  - pix_count increments on each handshake.
  - After the candidate with x == x1 retires, go to DONE.
- Latency: start accepted at cycle T gives the first pix_valid at T+4 (IDLE->LOAD->SETUP->INIT->STEP, with outputs registered). Throughput is 1 pixel per clock while pix_ready=1.
- DONE: pulse done for one cycle and drop pix_valid, then go to IDLE. A new start is accepted no earlier than the cycle after DONE.
- Degenerate line (x0==x1, y0==y1): exactly one candidate pixel is produced.
- Fully off-screen line: no pix_valid; done follows after dx+1 STEP cycles.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; pix_valid drops on the next edge without a handshake.
  - No done pulse; pix_count holds its value.
  - abort takes priority over pix_ready in the same cycle; that pixel counts as accepted only if the handshake occurred in that cycle.
- Arithmetic: all deltas and err use COORD_W+2 signed bits, so no overflow occurs for any endpoint pair.

Test Plan:
- Horizontal line (0,0)->(3,0), pix_ready=1: pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles, first at T+4; done one cycle after the last; pix_count=4.
- Steep reversed line (2,5)->(0,0): pixels in order (0,0),(0,1),(1,2),(1,3),(2,4),(2,5); pix_count=6.
- Backpressure on (0,0)->(3,0): toggle pix_ready 1,0,0,1,... Each pixel is held stable while ready=0; no pixel is dropped or duplicated; order is unchanged.
- Clipping, CLIP_EN=1, (-2,0)->(1,0): only (0,0),(1,0) are emitted; done arrives after 4 STEP cycles; pix_count=2. Line (700,10)->(705,10): no pix_valid, done still pulses.
- Abort/reset: abort while the third pixel of (0,0)->(9,0) is valid with ready=0: valid drops next cycle, no done, pix_count=2, busy=0. Repeat with rst low: all outputs become 0 asynchronously.
- Start while busy and single-point line: a second start during a line is ignored. Line (5,5)->(5,5) emits exactly (5,5), then done.
